// File: rtl/cmp_pipe_pkg.sv
// Shared types and helpers for the cmp_pipe comparator pipeline.
package cmp_pipe_pkg;

  typedef enum logic [2:0] {
    OP_EQ = 3'd0,
    OP_NE = 3'd1,
    OP_LT = 3'd2,
    OP_LE = 3'd3,
    OP_GT = 3'd4,
    OP_GE = 3'd5
  } cmp_op_e;

  localparam int unsigned CMP_OP_LAST = 5;

  // Codes above the last defined relation are reserved.
  function automatic logic is_reserved_op(input logic [2:0] op);
    return (op > 3'(CMP_OP_LAST));
  endfunction

endpackage

// File: rtl/cmp_lane.sv
// Single-lane combinational relational compare, signed or unsigned.
module cmp_lane
  import cmp_pipe_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             signed_mode,
  output logic             res
);

  // One extra bit holds the sign (or a zero) so a single signed compare
  // covers both modes without any subtraction overflow.
  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic           eq;
  logic           lt;

  assign ext_a = {signed_mode & a[WIDTH-1], a};
  assign ext_b = {signed_mode & b[WIDTH-1], b};
  assign eq    = (a == b);
  assign lt    = ($signed(ext_a) < $signed(ext_b));

  // Select the requested relation; reserved codes yield 0.
  always_comb begin
    res = 1'b0;
    case (op)
      OP_EQ:   res = eq;
      OP_NE:   res = !eq;
      OP_LT:   res = lt;
      OP_LE:   res = lt || eq;
      OP_GT:   res = !(lt || eq);
      OP_GE:   res = !lt;
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage valid/ready pipelined multi-lane comparator.
// Optional hit counter enabled by defining CMP_PIPE_HIT_COUNT_EN.
module cmp_pipe
  import cmp_pipe_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int LANES = 1
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESETN,
  input  logic [LANES*WIDTH-1:0] I0,
  input  logic [LANES*WIDTH-1:0] I1,
  input  logic [2:0]             OP,
  input  logic                   SIGNED,
  input  logic                   I_VALID,
  output logic                   I_READY,
  output logic [LANES-1:0]       O,
  output logic                   O_ANY,
  output logic                   O_ALL,
  output logic                   O_ERR,
  output logic                   O_VALID,
  input  logic                   O_READY
`ifdef CMP_PIPE_HIT_COUNT_EN
  ,
  output logic [31:0]            HIT_CNT,
  input  logic                   HIT_CLR
`endif
);

  logic                   s1_valid;
  logic [LANES*WIDTH-1:0] s1_i0;
  logic [LANES*WIDTH-1:0] s1_i1;
  logic [2:0]             s1_op;
  logic                   s1_signed;
  logic                   s2_valid;

  logic                   s1_load;
  logic                   s2_load;
  logic [LANES-1:0]       lane_res;
  logic [LANES-1:0]       lane_res_m;
  logic                   s1_err;

  assign s2_load = s1_valid && (!s2_valid || O_READY);
  assign I_READY = !s1_valid || s2_load;
  assign s1_load = I_VALID && I_READY;
  assign O_VALID = s2_valid;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cmp_lane #(.WIDTH(WIDTH)) u_lane (
      .a           (s1_i0[k*WIDTH +: WIDTH]),
      .b           (s1_i1[k*WIDTH +: WIDTH]),
      .op          (s1_op),
      .signed_mode (s1_signed),
      .res         (lane_res[k])
    );
  end

  assign s1_err     = is_reserved_op(s1_op);
  assign lane_res_m = s1_err ? '0 : lane_res;

  // Stage 1: capture operands and mode on an input transfer.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      s1_valid  <= 1'b0;
      s1_i0     <= '0;
      s1_i1     <= '0;
      s1_op     <= '0;
      s1_signed <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid  <= 1'b1;
        s1_i0     <= I0;
        s1_i1     <= I1;
        s1_op     <= OP;
        s1_signed <= SIGNED;
      end else if (s2_load) begin
        s1_valid  <= 1'b0;
      end
    end
  end

  // Stage 2: register lane results, reductions and error; hold while stalled.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      s2_valid <= 1'b0;
      O        <= '0;
      O_ANY    <= 1'b0;
      O_ALL    <= 1'b0;
      O_ERR    <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        O        <= lane_res_m;
        O_ANY    <= |lane_res_m;
        O_ALL    <= (&lane_res_m) && !s1_err;
        O_ERR    <= s1_err;
      end else if (O_READY) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef CMP_PIPE_HIT_COUNT_EN
  // Count output transfers with any lane hit; saturating, clear has priority.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      HIT_CNT <= '0;
    end else if (HIT_CLR) begin
      HIT_CNT <= '0;
    end else if (s2_valid && O_READY && O_ANY && (HIT_CNT != '1)) begin
      HIT_CNT <= HIT_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed self-checking bench for cmp_pipe: three lockstep instances
// (7-bit x1, 7-bit x4, 1-bit x1) sharing OP/SIGNED/handshake signals.
module tb_cmp_pipe;

  logic        clk;
  logic        rst_n;
  logic [2:0]  op;
  logic        sgn;
  logic        i_valid;
  logic        o_ready;

  logic [6:0]  i0_1, i1_1;
  logic [27:0] i0_4, i1_4;
  logic [0:0]  i0_w, i1_w;

  logic        rdy1, any1, all1, err1, vld1;
  logic [0:0]  o1;
  logic        rdy4, any4, all4, err4, vld4;
  logic [3:0]  o4;
  logic        rdyw, anyw, allw, errw, vldw;
  logic [0:0]  ow;

  logic        hit_clr;
  logic [31:0] hit1, hit4, hitw;

  int checks = 0;
  int errors = 0;

  cmp_pipe #(.WIDTH(7), .LANES(1)) u_dut1 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I0(i0_1), .I1(i1_1), .OP(op), .SIGNED(sgn),
    .I_VALID(i_valid), .I_READY(rdy1), .O(o1), .O_ANY(any1), .O_ALL(all1),
    .O_ERR(err1), .O_VALID(vld1), .O_READY(o_ready)
`ifdef CMP_PIPE_HIT_COUNT_EN
    , .HIT_CNT(hit1), .HIT_CLR(hit_clr)
`endif
  );

  cmp_pipe #(.WIDTH(7), .LANES(4)) u_dut4 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I0(i0_4), .I1(i1_4), .OP(op), .SIGNED(sgn),
    .I_VALID(i_valid), .I_READY(rdy4), .O(o4), .O_ANY(any4), .O_ALL(all4),
    .O_ERR(err4), .O_VALID(vld4), .O_READY(o_ready)
`ifdef CMP_PIPE_HIT_COUNT_EN
    , .HIT_CNT(hit4), .HIT_CLR(hit_clr)
`endif
  );

  cmp_pipe #(.WIDTH(1), .LANES(1)) u_dutw (
    .CLK(clk), .ASYNCRESETN(rst_n), .I0(i0_w), .I1(i1_w), .OP(op), .SIGNED(sgn),
    .I_VALID(i_valid), .I_READY(rdyw), .O(ow), .O_ANY(anyw), .O_ALL(allw),
    .O_ERR(errw), .O_VALID(vldw), .O_READY(o_ready)
`ifdef CMP_PIPE_HIT_COUNT_EN
    , .HIT_CNT(hitw), .HIT_CLR(hit_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat table: stimulus plus hand-computed expectations.
  logic [6:0]  b_i0_1 [8];
  logic [6:0]  b_i1_1 [8];
  logic [27:0] b_i0_4 [8];
  logic [27:0] b_i1_4 [8];
  logic [0:0]  b_i0_w [8];
  logic [0:0]  b_i1_w [8];
  logic [2:0]  b_op   [8];
  logic        b_sg   [8];
  logic        e_o1   [8];
  logic        e_err  [8];
  logic [3:0]  e_o4   [8];
  logic        e_any4 [8];
  logic        e_all4 [8];
  logic        e_ow   [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int idx,
                          input logic [6:0] a1, input logic [6:0] b1,
                          input logic [27:0] a4, input logic [27:0] b4,
                          input logic aw, input logic bw,
                          input logic [2:0] bop, input logic bsg,
                          input logic x1, input logic xerr,
                          input logic [3:0] x4, input logic xany, input logic xall,
                          input logic xw);
    b_i0_1[idx] = a1;   b_i1_1[idx] = b1;
    b_i0_4[idx] = a4;   b_i1_4[idx] = b4;
    b_i0_w[idx] = aw;   b_i1_w[idx] = bw;
    b_op[idx]   = bop;  b_sg[idx]   = bsg;
    e_o1[idx]   = x1;   e_err[idx]  = xerr;
    e_o4[idx]   = x4;   e_any4[idx] = xany; e_all4[idx] = xall;
    e_ow[idx]   = xw;
  endtask

  task automatic drive_beat(input int idx);
    i0_1 = b_i0_1[idx]; i1_1 = b_i1_1[idx];
    i0_4 = b_i0_4[idx]; i1_4 = b_i1_4[idx];
    i0_w = b_i0_w[idx]; i1_w = b_i1_w[idx];
    op   = b_op[idx];   sgn  = b_sg[idx];
  endtask

  task automatic check_out(input int idx);
    chk("o1",   32'(o1),   32'(e_o1[idx]));
    chk("any1", 32'(any1), 32'(e_o1[idx]));
    chk("all1", 32'(all1), 32'(e_o1[idx]));
    chk("err1", 32'(err1), 32'(e_err[idx]));
    chk("o4",   32'(o4),   32'(e_o4[idx]));
    chk("any4", 32'(any4), 32'(e_any4[idx]));
    chk("all4", 32'(all4), 32'(e_all4[idx]));
    chk("err4", 32'(err4), 32'(e_err[idx]));
    chk("ow",   32'(ow),   32'(e_ow[idx]));
    chk("vld4", 32'(vld4), 32'd1);
    chk("vldw", 32'(vldw), 32'd1);
  endtask

  // Stream n table beats, optionally holding O_READY low for cycles [lo..hi].
  task automatic stream(input int n, input int lo, input int hi);
    int  in_idx  = 0;
    int  out_idx = 0;
    bit  stall   = (lo <= hi);
    for (int c = 0; c < 40 && out_idx < n; c++) begin
      @(posedge clk); #1;
      o_ready = !(c >= lo && c <= hi);
      if (in_idx < n) begin
        i_valid = 1'b1;
        drive_beat(in_idx);
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (c < 2) chk("vld_early", 32'(vld1), 32'd0);
      if (vld1 && o_ready) begin
        check_out(out_idx);
        if (!stall) chk("latency", 32'(c), 32'(out_idx + 2));
        out_idx++;
      end else if (vld1 && !o_ready) begin
        chk("stall_rdy1", 32'(rdy1), 32'd0);
        chk("stall_rdy4", 32'(rdy4), 32'd0);
        chk("stall_rdyw", 32'(rdyw), 32'd0);
        check_out(out_idx);
      end
      if (i_valid && rdy1) in_idx++;
    end
    chk("stream_in_count",  32'(in_idx),  32'(n));
    chk("stream_out_count", 32'(out_idx), 32'(n));
    i_valid = 1'b0;
    o_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    op      = '0;
    sgn     = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    hit_clr = 1'b0;
    i0_1 = '0; i1_1 = '0; i0_4 = '0; i1_4 = '0; i0_w = '0; i1_w = '0;
    hit1 = '0; hit4 = '0; hitw = '0;

    // Reset state
    #1;
    chk("rst_vld1", 32'(vld1), 32'd0);
    chk("rst_vld4", 32'(vld4), 32'd0);
    chk("rst_o4",   32'(o4),   32'd0);
    chk("rst_any4", 32'(any4), 32'd0);
    chk("rst_all4", 32'(all4), 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
    chk("rst_rdy1", 32'(rdy1), 32'd1);
    #11 rst_n = 1'b1;

    // Relation / signedness vectors, streamed back to back
    //        i0_1   i1_1   i0_4                          i1_4                          w0 w1 op    sg  o1 er o4     any all ow
    set_beat(0, 7'h7F, 7'h01, {7'h3F,7'h40,7'h01,7'h7F}, {7'h3F,7'h3F,7'h7F,7'h01}, 1, 0, 3'd5, 1, 0, 0, 4'hA, 1, 0, 0);
    set_beat(1, 7'h7F, 7'h01, {7'h3F,7'h40,7'h01,7'h7F}, {7'h3F,7'h3F,7'h7F,7'h01}, 1, 0, 3'd5, 0, 1, 0, 4'hD, 1, 0, 1);
    set_beat(2, 7'h40, 7'h3F, {7'h3F,7'h40,7'h01,7'h7F}, {7'h3F,7'h3F,7'h7F,7'h01}, 1, 0, 3'd2, 1, 1, 0, 4'h5, 1, 0, 1);
    set_beat(3, 7'h40, 7'h3F, {7'h3F,7'h40,7'h01,7'h7F}, {7'h3F,7'h3F,7'h7F,7'h01}, 1, 0, 3'd4, 1, 0, 0, 4'h2, 1, 0, 0);
    set_beat(4, 7'h40, 7'h40, {7'h12,7'h12,7'h12,7'h12}, {7'h12,7'h12,7'h12,7'h12}, 1, 1, 3'd0, 1, 1, 0, 4'hF, 1, 1, 1);
    set_beat(5, 7'h05, 7'h05, {7'h11,7'h22,7'h33,7'h44}, {7'h11,7'h23,7'h33,7'h45}, 0, 0, 3'd1, 0, 0, 0, 4'h5, 1, 0, 0);
    set_beat(6, 7'h7F, 7'h7F, {7'h3F,7'h40,7'h01,7'h7F}, {7'h3F,7'h3F,7'h7F,7'h01}, 0, 1, 3'd3, 1, 1, 0, 4'hD, 1, 0, 0);
    stream(7, 1, 0);

    // Backpressure: 5 beats (LT unsigned), O_READY low for cycles 3..6
    set_beat(0, 7'd0, 7'd2, {7'd0,7'd0,7'd0,7'd0}, {7'd4,7'd3,7'd2,7'd1}, 0, 1, 3'd2, 0, 1, 0, 4'hF, 1, 1, 1);
    set_beat(1, 7'd1, 7'd2, {7'd1,7'd1,7'd1,7'd1}, {7'd4,7'd3,7'd2,7'd1}, 1, 1, 3'd2, 0, 1, 0, 4'hE, 1, 0, 0);
    set_beat(2, 7'd2, 7'd2, {7'd2,7'd2,7'd2,7'd2}, {7'd4,7'd3,7'd2,7'd1}, 0, 1, 3'd2, 0, 0, 0, 4'hC, 1, 0, 1);
    set_beat(3, 7'd3, 7'd2, {7'd3,7'd3,7'd3,7'd3}, {7'd4,7'd3,7'd2,7'd1}, 1, 1, 3'd2, 0, 0, 0, 4'h8, 1, 0, 0);
    set_beat(4, 7'd4, 7'd2, {7'd4,7'd4,7'd4,7'd4}, {7'd4,7'd3,7'd2,7'd1}, 0, 1, 3'd2, 0, 0, 0, 4'h0, 0, 0, 1);
    stream(5, 3, 6);

    // Reserved opcode between two valid beats
    set_beat(0, 7'd3, 7'd3, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}, 1, 1, 3'd0, 0, 1, 0, 4'hF, 1, 1, 1);
    set_beat(1, 7'd3, 7'd3, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}, 1, 1, 3'd6, 1, 0, 1, 4'h0, 0, 0, 0);
    set_beat(2, 7'd5, 7'd3, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}, 1, 1, 3'd5, 0, 1, 0, 4'hF, 1, 1, 1);
    stream(3, 1, 0);
    chk("errw_after", 32'(errw), 32'd0);

    // Reset asserted mid-stream between clock edges
    @(posedge clk); #1;
    o_ready = 1'b1;
    i_valid = 1'b1;
    drive_beat(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("inflight_vld1", 32'(vld1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld1", 32'(vld1), 32'd0);
    chk("midrst_vld4", 32'(vld4), 32'd0);
    chk("midrst_vldw", 32'(vldw), 32'd0);
    chk("midrst_o4",   32'(o4),   32'd0);
    chk("midrst_rdy1", 32'(rdy1), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("post_rst_vld1", 32'(vld1), 32'd0);
      chk("post_rst_vld4", 32'(vld4), 32'd0);
    end

`ifdef CMP_PIPE_HIT_COUNT_EN
    chk("hit_after_rst", hit1, 32'd0);
    set_beat(0, 7'd3, 7'd3, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}, 1, 1, 3'd0, 0, 1, 0, 4'hF, 1, 1, 1);
    set_beat(1, 7'd3, 7'd3, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}, 1, 1, 3'd0, 0, 1, 0, 4'hF, 1, 1, 1);
    set_beat(2, 7'd5, 7'd3, {7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10}, 1, 1, 3'd5, 0, 1, 0, 4'hF, 1, 1, 1);
    stream(3, 1, 0);
    @(posedge clk); #1;
    chk("hit_count3", hit1, 32'd3);
    chk("hit4_count3", hit4, 32'd3);
    hit_clr = 1'b1;
    @(posedge clk); #1;
    hit_clr = 1'b0;
    chk("hit_cleared", hit1, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_pipe.md
Name: cmp_pipe

Overview:
- Parametrised, pipelined successor to the single-shot signed ≥ comparator primitive.
- Compares LANES independent pairs of WIDTH-bit operands in one transaction.
- A runtime opcode selects the relation (eq/ne/lt/le/gt/ge); a runtime flag selects signed or unsigned interpretation.
- Sits between stream producers and consumers in generated datapaths, using valid/ready handshakes on both sides and a fixed 2-cycle latency.

Parameters:
- WIDTH, 7, operand width per lane in bits; must be ≥ 1.
- LANES, 1, number of parallel comparison lanes; must be ≥ 1.

Ports:
- CLK, in, 1, clock; all state updates on the rising edge.
- ASYNCRESETN, in, 1, asynchronous active-low reset.
- I0, in, LANES*WIDTH, left operands; lane k occupies bits [k*WIDTH +: WIDTH].
- I1, in, LANES*WIDTH, right operands; same packing as I0.
- OP, in, 3, relation code: 0 eq, 1 ne, 2 lt, 3 le, 4 gt, 5 ge, 6–7 reserved.
- SIGNED, in, 1, 1 = two's-complement compare, 0 = unsigned compare.
- I_VALID, in, 1, input beat valid.
- I_READY, out, 1, block can accept an input beat.
- O, out, LANES, per-lane result of (I0 OP I1).
- O_ANY, out, 1, OR of O.
- O_ALL, out, 1, AND of O.
- O_ERR, out, 1, beat carried a reserved OP.
- O_VALID, out, 1, output beat valid.
- O_READY, in, 1, downstream accepts the output beat.

Behaviour:
- Reset: asynchronous on ASYNCRESETN low; release is synchronised by the surrounding design.
  - While reset is asserted, both stage-valid flags clear, so O_VALID=0.
  - O, O_ANY, O_ALL and O_ERR reset to 0.
  - I_READY=1 immediately after reset.
- Pipeline, stage 1 (S1): registers I0, I1, OP and SIGNED on an input transfer (I_VALID && I_READY).
- Pipeline, stage 2 (S2): registers the computed lane results, reductions and error flag.
- Latency: exactly 2 cycles from input transfer to O_VALID when O_READY is held high.
- Throughput: 1 beat per cycle when O_READY is held high.
- Stage advance:
  - S2 loads when S1 is valid and (S2 is empty or O_READY=1).
  - S1 loads when I_VALID and (S1 is empty or S1 advances this cycle).
  - I_READY = !s1_valid || s2_load. It is combinational from O_READY; no skid buffer is used.
- Output stability: while O_VALID=1 and O_READY=0, all outputs hold stable and no data is lost.
- Output transfer: occurs on O_VALID && O_READY. Simultaneous input and output transfers in one cycle are legal and lose no beat.
- Arithmetic:
  - SIGNED=1: both operands are treated as two's complement. The MSB is the sign; compare uses WIDTH+1-bit sign-extended values.
  - SIGNED=0: both operands are zero-extended.
  - Lane ordering: O[k] belongs to lane k.
- Reserved OP (6 or 7): O=0, O_ANY=0, O_ALL=0, O_ERR=1. The beat still passes normally and is not dropped.
- Boundary cases:
  - WIDTH=1 signed: value 1 equals −1, so 1 ≥ 0 is false.
  - Most-negative vs most-positive values must compare correctly; no subtraction overflow is permitted.
- Reset mid-operation: in-flight beats are discarded and none are emitted after reset release.

Optional Feature:
- Macro: CMP_PIPE_HIT_COUNT_EN.
- When defined:
  - Adds output HIT_CNT (32 bits) and input HIT_CLR (1 bit).
  - HIT_CNT increments by 1 on each output transfer with O_ANY=1.
  - HIT_CNT saturates at all-ones.
  - It is cleared by reset or by HIT_CLR=1; clear wins over increment in the same cycle.
- When undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package cmp_pipe_pkg holds:
  - typedef cmp_op_e (3-bit enum: OP_EQ..OP_GE);
  - constant CMP_OP_LAST = 5;
  - function is_reserved_op().
- One sub-module, cmp_lane: purely combinational, WIDTH parameter, inputs a, b, op, signed_mode, output res. It is instantiated LANES times in a generate loop feeding S2.

Test Plan:
1. WIDTH=7, LANES=1, SIGNED=1, OP=ge, I0=7'h7F (−1), I1=7'h01 → after 2 cycles O=0, O_ERR=0. Same beat with SIGNED=0 → O=1.
2. Signed extremes: I0=7'h40 (−64), I1=7'h3F (63), OP=lt, SIGNED=1 → O=1. OP=gt → O=0. OP=eq with I0=I1=7'h40 → O=1.
3. LANES=4, OP=ne, lanes differ in lanes 0 and 2 only → O=4'b0101, O_ANY=1, O_ALL=0.
4. Backpressure: stream 5 beats with O_READY low for cycles 3–6 → no loss, no duplication, in-order results, outputs stable while stalled, I_READY low once S1 and S2 are full.
5. OP=6 beat between two valid beats → middle result O=0, O_ERR=1; neighbouring beats are correct.
6. Assert ASYNCRESETN low mid-stream between clock edges → O_VALID=0 immediately, no stale beat after release. With CMP_PIPE_HIT_COUNT_EN defined, HIT_CNT=0 after reset and counts 3 after 3 matching transfers.
